// File: rtl/ppu_vga_doubler.sv
// ppu_vga_doubler
//   Captures the PPU's 256x240 pixel stream into two ping-pong line buffers.
//   It replays each NES line twice at 640x480 VGA timing. Each pixel is
//   doubled horizontally, and the 512-wide image is centred with a border
//   colour on either side. Everything runs on clk; the PPU and VGA pixel rates
//   arrive as clock enables.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   ppu_ce              PPU inputs valid this cycle
//   ppu_pixel [7:0]     PPU palette colour
//   ppu_x [8:0]         PPU dot 0..340
//   ppu_y [8:0]         PPU scanline 0..260, 9'h1FF = pre-render
//   vga_ce              one strobe per VGA pixel
//   vga_color [7:0]     registered pixel colour (0 outside display enable)
//   vga_hs, vga_vs      registered syncs, active low
//   vga_de              registered display enable
//   locked              high while replaying a frame
//   overrun             one-cycle pulse: PPU wrote the bank being displayed
module ppu_vga_doubler #(
  parameter int unsigned H_OFFSET     = 64,
  parameter logic [7:0]  BORDER_COLOR = 8'h0F,
  parameter int unsigned HS_START     = 656,
  parameter int unsigned HS_END       = 752,
  parameter int unsigned VS_START     = 490,
  parameter int unsigned VS_END       = 492
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ppu_ce,
  input  logic [7:0] ppu_pixel,
  input  logic [8:0] ppu_x,
  input  logic [8:0] ppu_y,
  input  logic       vga_ce,
  output logic [7:0] vga_color,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de,
  output logic       locked,
  output logic       overrun
);

  localparam logic [9:0] H_LAST  = 10'd799;
  localparam logic [9:0] V_LAST  = 10'd524;
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] IMG_LO  = 10'(H_OFFSET);
  localparam logic [9:0] IMG_HI  = 10'(H_OFFSET + 512);
  localparam logic [9:0] HS_LO   = 10'(HS_START);
  localparam logic [9:0] HS_HI   = 10'(HS_END);
  localparam logic [9:0] VS_LO   = 10'(VS_START);
  localparam logic [9:0] VS_HI   = 10'(VS_END);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t     state, state_nxt;
  logic [9:0] h, v;
  logic       line0_done;
  logic       h_wrap;
  logic       line0_set;

  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] rd_col;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] line_buf [512];

  logic       s1_hs, s1_vs, s1_de, s1_img;
  logic       hs_now, vs_now, de_now, img_now;

  assign h_wrap    = vga_ce && (h == H_LAST);
  assign line0_set = ppu_ce && (ppu_y == 9'd0) && (ppu_x == 9'd256);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SYNC;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SYNC: if (h_wrap && line0_done)  state_nxt = RUN;
      RUN:       if (h_wrap && v == V_LAST) state_nxt = WAIT_SYNC;
      default:   state_nxt = WAIT_SYNC;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    locked = (state == RUN);
  end

  // ---------------- raster counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= V_LAST;
    end else if (vga_ce) begin
      h <= h_wrap ? '0 : h + 10'd1;
      if (h_wrap) begin
        if (state == WAIT_SYNC) begin
          if (line0_done) v <= '0;
        end else if (v != V_LAST) begin
          v <= v + 10'd1;
        end
      end
    end
  end

  // A set in the same cycle as the consuming wrap wins, so it is seen next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             line0_done <= 1'b0;
    else if (line0_set)                     line0_done <= 1'b1;
    else if (h_wrap && state == WAIT_SYNC)  line0_done <= 1'b0;
  end

  // ---------------- line buffers ----------------
  assign wr_en   = ppu_ce && (ppu_y < 9'd240) && (ppu_x < 9'd256);
  assign wr_addr = {ppu_y[0], ppu_x[7:0]};
  assign rd_col  = 8'((h - IMG_LO) >> 1);
  assign rd_addr = {v[1], rd_col};

  // The registered read is the stage-1 address/data register; a read and a
  // write to the same address in one cycle return the old contents.
  always_ff @(posedge clk) begin
    if (wr_en)  line_buf[wr_addr] <= ppu_pixel;
    if (vga_ce) rd_data <= line_buf[rd_addr];
  end

  // ---------------- timing decode ----------------
  always_comb begin
    de_now  = (state == RUN) && (h < H_VIS) && (v < V_VIS);
    img_now = (h >= IMG_LO) && (h < IMG_HI);
    hs_now  = !((h >= HS_LO) && (h < HS_HI));
    vs_now  = (state == WAIT_SYNC) || !((v >= VS_LO) && (v < VS_HI));
  end

  // ---------------- two-stage output pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_de     <= 1'b0;
      s1_img    <= 1'b0;
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_de    <= 1'b0;
      vga_color <= '0;
    end else if (vga_ce) begin
      s1_hs     <= hs_now;
      s1_vs     <= vs_now;
      s1_de     <= de_now;
      s1_img    <= img_now;
      vga_hs    <= s1_hs;
      vga_vs    <= s1_vs;
      vga_de    <= s1_de;
      vga_color <= !s1_de ? '0 : (s1_img ? rd_data : BORDER_COLOR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= wr_en && (ppu_y[0] == v[1]) && (state == RUN) && (v < V_VIS);
  end

endmodule

// File: doc/ppu_vga_doubler.md
Name: ppu_vga_doubler

Overview:
- Downstream of the PPU. Captures the PPU's 256x240 pixel stream (8-bit palette colour per pixel) into two ping-pong line buffers.
- Replays each NES line twice at VGA 640x480 timing: each pixel doubled horizontally, the 512x480 image centred with a border colour either side.
- Runs on one system clock. PPU and VGA pixel rates arrive as clock enables, so no clock-domain crossing exists inside the block.

Parameters:
- H_OFFSET, 64: first VGA column of NES pixel 0.
- BORDER_COLOR, 8'h0F: colour driven in visible area outside the NES image.
- HS_START, 656 / HS_END, 752: hsync low for h in [HS_START, HS_END).
- VS_START, 490 / VS_END, 492: vsync low for v in [VS_START, VS_END).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ppu_ce  input  1  one-cycle strobe: PPU inputs valid this cycle.
- ppu_pixel  input  8  PPU pixel colour.
- ppu_x  input  9  PPU pixel count, 0..340.
- ppu_y  input  9  PPU scanline, 0..260; 9'h1FF = pre-render.
- vga_ce  input  1  one-cycle strobe per VGA pixel.
- vga_color  output  8  pixel colour, registered.
- vga_hs  output  1  hsync, active low, registered.
- vga_vs  output  1  vsync, active low, registered.
- vga_de  output  1  display enable, registered.
- locked  output  1  high while in RUN.
- overrun  output  1  one-cycle pulse on a write/read bank collision.

Behaviour:
- Reset values: vga_color=0, vga_hs=1, vga_vs=1, vga_de=0, locked=0, overrun=0, h=0, v=524, state=WAIT_SYNC, line0_done=0. Buffer contents are undefined.
- Write side:
  - On ppu_ce with ppu_y<240 and ppu_x<256, write ppu_pixel to bank[ppu_y[0]][ppu_x[7:0]].
  - On ppu_ce with ppu_y==0 and ppu_x==256, set sticky flag line0_done.
- Counters:
  - h (10 bits) advances only on vga_ce: 0..799, then wraps to 0.
  - v (10 bits) advances only on vga_ce with h==799: 0..524.
- State WAIT_SYNC:
  - h runs freely, v is held at 524; hsync is produced, de=0, vs=1.
  - On vga_ce with h==799 and line0_done=1: v<=0, clear line0_done, go to RUN.
  - If line0_done is set by ppu_ce in that same cycle, it is seen on the next wrap.
- State RUN:
  - On vga_ce with h==799 and v==524: go to WAIT_SYNC, v stays 524.
  - This relocks every frame. The integrator must ensure the VGA frame is shorter than the PPU frame.
- Read address:
  - NES line ny = v[9:1], read bank = ny[0].
  - NES column nx = (h - H_OFFSET)[9:1], valid when H_OFFSET <= h < H_OFFSET+512.
  - The buffer read is synchronous, one clk.
- Pipeline (two vga_ce stages):
  - Stage 1 registers the address plus hs/vs/de/in_image.
  - Stage 2 registers the outputs.
  - Outputs on the k-th vga_ce reflect the h/v of the (k-2)-th vga_ce.
  - vga_de = RUN and h<640 and v<480.
  - vga_color = buffer data when de and in_image; BORDER_COLOR when de and not in_image; 0 when de=0.
- Sync: hs/vs are decoded from h/v using the parameters; vs is forced to 1 in WAIT_SYNC.
- overrun: pulses when a ppu_ce write targets bank==read bank while RUN and v<480. The write still occurs.
- Same-address write and read in one cycle: read returns the old data.
- Reset mid-frame: immediately returns to the reset values; the next frame waits for a fresh line0_done.

Test Plan:
- Reset, then hold ppu_ce=0 -> locked=0, vga_vs=1 forever, vga_hs toggles with period 800 vga_ce, vga_de=0.
- Feed PPU line 0 with pixel=x[7:0] and line 1 with pixel=8'h80|x[6:0], then reach x=256 on line 0 -> locked rises at the next h wrap.
  - VGA lines 0 and 1 show colours 0,0,1,1..255,255 at h=64..575 (seen two vga_ce later).
  - VGA lines 2 and 3 show line 1's data.
- In RUN, check h=0..63 and 576..639 -> vga_color=8'h0F, vga_de=1; h=640..799 -> vga_de=0, vga_color=0; vga_hs=0 exactly for h=656..751.
- Check vsync: vga_vs=0 only on v=490,491. After v=524 wraps -> locked=0 until the next PPU line-0 completion.
- Force a PPU write to line 2 (bank 0) while the VGA is reading line 0 -> overrun=1 for one cycle; later readback of line 2 is correct.
- Assert rst_n=0 mid-line at v=100 -> outputs go to reset values asynchronously. After release, locked stays 0 until a new line-0 completion.
